// File: rtl/mul_unit_seq_if.sv
// Request/response bundle between the execute stage and the iterative
// multiplier.
//   start  : request a multiply (sampled only when the unit is idle)
//   op     : 00 MUL, 01 SMULH, 10 UMULH, 11 MUL
//   A, B   : multiplicand / multiplier, latched on accept
//   busy   : unit is iterating or finishing; stalls the pipeline
//   done   : one-cycle completion pulse
//   result : registered product slice, held until the next done
interface mul_unit_seq_if #(parameter int N = 64);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  modport master (output start, op, A, B, input busy, done, result);
  modport slave  (input start, op, A, B, output busy, done, result);
endinterface

// File: rtl/mul_unit_seq.sv
// Iterative radix-2 shift-add multiplier (MUL / SMULH / UMULH).
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset, wins over everything
//   bus   : mul_unit_seq_if.slave (start/op/A/B in, busy/done/result out)
// One partial product per cycle. Signed high multiplies run on operand
// magnitudes and apply the sign across the full 2N-bit product at the end.
module mul_unit_seq #(
  parameter int N = 64
) (
  input  logic           clk,
  input  logic           reset,
  mul_unit_seq_if.slave  bus
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [N-1:0]   ONE_N  = N'(1);
  localparam logic [2*N-1:0] ONE_2N = (2*N)'(1);

  typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_e;

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic           sign_q, sign_d;
  logic [2*N-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each iteration
  logic [N-1:0]   mplier_q, mplier_d; // multiplier, shifted right each iteration
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   result_q, result_d;
  logic           done_q, done_d;

  logic           is_smulh;
  logic [N-1:0]   mag_a, mag_b;
  logic [2*N-1:0] prod;
  logic [CW-1:0]  cnt_inc;

  assign is_smulh = (bus.op == 2'b01);
  // |-2^(N-1)| wraps to 2^(N-1), which is still correct as an unsigned N-bit value
  assign mag_a    = (is_smulh && bus.A[N-1]) ? (~bus.A + ONE_N) : bus.A;
  assign mag_b    = (is_smulh && bus.B[N-1]) ? (~bus.B + ONE_N) : bus.B;
  assign prod     = sign_q ? (~acc_q + ONE_2N) : acc_q;
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_d   = sign_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          mcand_d  = {{N{1'b0}}, mag_a};
          mplier_d = mag_b;
          sign_d   = is_smulh & (bus.A[N-1] ^ bus.B[N-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_inc;
        if (cnt_inc == CW'(N)) state_d = FINISH;
      end
      FINISH: begin
        result_d = (op_q == 2'b01 || op_q == 2'b10) ? prod[2*N-1:N] : prod[N-1:0];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule
